trap_csr_unit: RTL and testbench

- Machine-mode trap CSR block directly downstream of the interrupt controller.
- Consumes trap_entry_en, trap_exit_en and int_index. Holds mstatus.MIE/MPIE, mtvec, mepc, mcause and mscratch.
- Produces int_mstatus_mie, which feeds back to the interrupt controller, plus a one-cycle PC redirect to the handler vector or to mepc.
- Gives the pipeline a CSR read/modify/write port.

---
 rtl/trap_csr_if.sv | 28 ++
 rtl/trap_csr_unit.sv | 154 +++++++++++++++
 tb/tb_trap_csr_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/trap_csr_if.sv
// Trap/CSR bus between the interrupt controller + pipeline (master) and the
// machine-mode trap CSR block (slave).
interface trap_csr_if;
    logic        trap_entry_en;
    logic        trap_exit_en;
    logic [3:0]  int_index;
    logic [31:0] epc_in;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        int_mstatus_mie;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        in_trap;

    modport master (
        output trap_entry_en, trap_exit_en, int_index, epc_in,
               csr_op, csr_addr, csr_wdata,
        input  csr_rdata, int_mstatus_mie, redirect_en, redirect_pc, in_trap
    );

    modport slave (
        input  trap_entry_en, trap_exit_en, int_index, epc_in,
               csr_op, csr_addr, csr_wdata,
        output csr_rdata, int_mstatus_mie, redirect_en, redirect_pc, in_trap
    );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap CSR block: mstatus.MIE/MPIE, mtvec, mepc, mcause,
// mscratch, trap entry/exit sequencing and a one-cycle PC redirect strobe.
module trap_csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic        MIE_RESET   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    trap_csr_if.slave   bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

    localparam logic [31:0] MTVEC_RST_VAL = MTVEC_RESET & ~32'h0000_0002;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mscratch;
    logic        r_redirect_en;
    logic [31:0] r_redirect_pc;
    logic        r_in_trap;

    logic [31:0] w_rdata;
    logic [31:0] w_new;
    logic        w_wr;
    logic        w_event;
    logic [31:0] w_vec_base;
    logic [31:0] w_vec_pc;

    assign w_wr    = (csr_op_e'(bus.csr_op) != OP_NONE);
    assign w_event = bus.trap_entry_en | bus.trap_exit_en;

    // Read mux of current register values; also the "old" operand for set/clear.
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is inferred.
        w_rdata = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS:  w_rdata = {24'b0, r_mpie, 3'b0, r_mie, 3'b0};
            ADDR_MTVEC:    w_rdata = r_mtvec;
            ADDR_MSCRATCH: w_rdata = r_mscratch;
            ADDR_MEPC:     w_rdata = r_mepc;
            ADDR_MCAUSE:   w_rdata = r_mcause;
            default:       w_rdata = '0;
        endcase
    end

    // Read/modify/write operand before per-register forced bits are applied.
    always_comb begin
        w_new = '0;
        case (csr_op_e'(bus.csr_op))
            OP_WRITE: w_new = bus.csr_wdata;
            OP_SET:   w_new = w_rdata | bus.csr_wdata;
            OP_CLEAR: w_new = w_rdata & ~bus.csr_wdata;
            default:  w_new = w_rdata;
        endcase
    end

    // Handler target from the pre-write mtvec; vectored mode adds cause*4 with 32-bit wrap.
    assign w_vec_base = {r_mtvec[31:2], 2'b00};
    assign w_vec_pc   = r_mtvec[0] ? (w_vec_base + {26'b0, bus.int_index, 2'b00})
                                   : w_vec_base;

    // mstatus and handler-active flag: trap hardware has priority over CSR writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            r_mie     <= MIE_RESET;
            r_mpie    <= 1'b0;
            r_in_trap <= 1'b0;
        end else if (bus.trap_entry_en) begin
            r_mie     <= 1'b0;
            // Tail-chain: the original context's MIE was already saved, exit would restore MPIE=1.
            r_mpie    <= bus.trap_exit_en ? 1'b1 : r_mie;
            r_in_trap <= 1'b1;
        end else if (bus.trap_exit_en) begin
            r_mie     <= r_mpie;
            r_mpie    <= 1'b1;
            r_in_trap <= 1'b0;
        end else if (w_wr && bus.csr_addr == ADDR_MSTATUS) begin
            r_mie     <= w_new[3];
            r_mpie    <= w_new[7];
        end
    end

    // mepc/mcause: written by trap entry; software writes dropped during any trap event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mepc   <= '0;
            r_mcause <= '0;
        end else if (bus.trap_entry_en) begin
            // A tail-chained entry keeps the original return address.
            if (!bus.trap_exit_en) begin
                r_mepc <= {bus.epc_in[31:2], 2'b00};
            end
            r_mcause <= {1'b1, 27'b0, bus.int_index};
        end else if (w_wr && !w_event) begin
            if (bus.csr_addr == ADDR_MEPC) begin
                r_mepc <= {w_new[31:2], 2'b00};
            end
            if (bus.csr_addr == ADDR_MCAUSE) begin
                r_mcause <= w_new;
            end
        end
    end

    // mtvec/mscratch: software-only registers, writable even alongside trap events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtvec    <= MTVEC_RST_VAL;
            r_mscratch <= '0;
        end else if (w_wr) begin
            if (bus.csr_addr == ADDR_MTVEC) begin
                r_mtvec <= w_new & ~32'h0000_0002;
            end
            if (bus.csr_addr == ADDR_MSCRATCH) begin
                r_mscratch <= w_new;
            end
        end
    end

    // One-cycle redirect strobe per event; back-to-back events each get their own pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_en <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect_en <= w_event;
            if (bus.trap_entry_en) begin
                r_redirect_pc <= w_vec_pc;
            end else if (bus.trap_exit_en) begin
                r_redirect_pc <= r_mepc;
            end
        end
    end

    assign bus.csr_rdata       = w_rdata;
    assign bus.int_mstatus_mie = r_mie;
    assign bus.redirect_en     = r_redirect_en;
    assign bus.redirect_pc     = r_redirect_pc;
    assign bus.in_trap         = r_in_trap;
endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit with an expected-value queue.
module tb_trap_csr_unit;
    logic clk;
    logic rst_n;

    trap_csr_if bus_if ();

    trap_csr_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against an observed DUT value.
    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_inputs();
        bus_if.trap_entry_en = 1'b0;
        bus_if.trap_exit_en  = 1'b0;
        bus_if.int_index     = 4'h0;
        bus_if.epc_in        = 32'h0;
        bus_if.csr_op        = 2'b00;
        bus_if.csr_addr      = 12'h000;
        bus_if.csr_wdata     = 32'h0;
    endtask

    // Drive one cycle of stimulus at negedge, sample #1 after the next posedge.
    task automatic step(input logic en, input logic ex, input logic [3:0] idx,
                        input logic [31:0] epc, input logic [1:0] op,
                        input logic [11:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus_if.trap_entry_en = en;
        bus_if.trap_exit_en  = ex;
        bus_if.int_index     = idx;
        bus_if.epc_in        = epc;
        bus_if.csr_op        = op;
        bus_if.csr_addr      = addr;
        bus_if.csr_wdata     = wdata;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        step(1'b0, 1'b0, 4'h0, 32'h0, op, addr, wdata);
    endtask

    // Combinational read with no operation pending.
    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        expect_val(tag, exp);
        bus_if.csr_op   = 2'b00;
        bus_if.csr_addr = addr;
        #1;
        cmp(bus_if.csr_rdata);
    endtask

    task automatic redirect_expect(input string tag, input logic [31:0] pc);
        expect_val({tag, "_en"}, 32'h1);
        expect_val({tag, "_pc"}, pc);
    endtask

    task automatic redirect_check();
        cmp({31'b0, bus_if.redirect_en});
        cmp(bus_if.redirect_pc);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;

        // Reset state
        expect_val("rst_redirect_en", 32'h0); cmp({31'b0, bus_if.redirect_en});
        expect_val("rst_redirect_pc", 32'h0); cmp(bus_if.redirect_pc);
        expect_val("rst_in_trap", 32'h0);     cmp({31'b0, bus_if.in_trap});
        expect_val("rst_mie", 32'h0);         cmp({31'b0, bus_if.int_mstatus_mie});
        rd("rst_mtvec", 12'h305, 32'h0000_0100);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mscratch", 12'h340, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enable interrupts, direct mtvec
        csr_wr(2'b01, 12'h300, 32'h8);
        expect_val("wr_mie", 32'h1); cmp({31'b0, bus_if.int_mstatus_mie});
        csr_wr(2'b01, 12'h305, 32'h200);

        // Direct-mode entry
        redirect_expect("entry_direct", 32'h200);
        expect_val("entry_mie", 32'h0);
        expect_val("entry_in_trap", 32'h1);
        step(1'b1, 1'b0, 4'hF, 32'h1236, 2'b00, 12'h0, 32'h0);
        redirect_check();
        cmp({31'b0, bus_if.int_mstatus_mie});
        cmp({31'b0, bus_if.in_trap});
        rd("entry_mepc", 12'h341, 32'h1234);
        rd("entry_mcause", 12'h342, 32'h8000_000F);
        rd("entry_mstatus", 12'h300, 32'h80);

        // Strobe lasts one cycle only
        expect_val("redirect_one_cycle", 32'h0);
        csr_wr(2'b00, 12'h0, 32'h0);
        cmp({31'b0, bus_if.redirect_en});

        // Exit
        redirect_expect("exit", 32'h1234);
        expect_val("exit_in_trap", 32'h0);
        step(1'b0, 1'b1, 4'h0, 32'h0, 2'b00, 12'h0, 32'h0);
        redirect_check();
        cmp({31'b0, bus_if.in_trap});
        rd("exit_mstatus", 12'h300, 32'h88);

        // Vectored mode, back-to-back entries
        csr_wr(2'b01, 12'h305, 32'h201);
        rd("mtvec_vectored", 12'h305, 32'h201);
        redirect_expect("vec_idx4", 32'h210);
        step(1'b1, 1'b0, 4'h4, 32'h1234, 2'b00, 12'h0, 32'h0);
        redirect_check();
        redirect_expect("vec_idxE_b2b", 32'h238);
        step(1'b1, 1'b0, 4'hE, 32'h1234, 2'b00, 12'h0, 32'h0);
        redirect_check();

        // Tail-chain: entry and exit together
        redirect_expect("tail_chain", 32'h230);
        expect_val("tail_in_trap", 32'h1);
        step(1'b1, 1'b1, 4'hC, 32'h5000, 2'b00, 12'h0, 32'h0);
        redirect_check();
        cmp({31'b0, bus_if.in_trap});
        rd("tail_mepc", 12'h341, 32'h1234);
        rd("tail_mcause", 12'h342, 32'h8000_000C);
        rd("tail_mstatus", 12'h300, 32'h80);

        // Leave handler: MIE restored from MPIE=1
        redirect_expect("exit2", 32'h1234);
        step(1'b0, 1'b1, 4'h0, 32'h0, 2'b00, 12'h0, 32'h0);
        redirect_check();
        rd("exit2_mstatus", 12'h300, 32'h88);

        // mstatus write coincident with entry is dropped
        redirect_expect("entry_wr_drop", 32'h204);
        expect_val("wr_drop_mie", 32'h0);
        step(1'b1, 1'b0, 4'h1, 32'h4000, 2'b01, 12'h300, 32'h8);
        redirect_check();
        cmp({31'b0, bus_if.int_mstatus_mie});
        rd("wr_drop_mstatus", 12'h300, 32'h80);

        // mscratch set coincident with entry takes effect
        redirect_expect("entry_scratch", 32'h208);
        step(1'b1, 1'b0, 4'h2, 32'h4000, 2'b10, 12'h340, 32'hA5);
        redirect_check();
        rd("scratch_set", 12'h340, 32'hA5);

        // mtvec write coincident with entry: redirect uses pre-write mtvec
        redirect_expect("entry_mtvec_wr", 32'h20C);
        step(1'b1, 1'b0, 4'h3, 32'h4000, 2'b01, 12'h305, 32'h300);
        redirect_check();
        rd("mtvec_coincident", 12'h305, 32'h300);

        // Clear bits, forced bits, unmapped address
        csr_wr(2'b11, 12'h340, 32'h05);
        rd("scratch_clear", 12'h340, 32'hA0);
        csr_wr(2'b01, 12'h305, 32'hFFFF_FFFF);
        rd("mtvec_bit1", 12'h305, 32'hFFFF_FFFD);
        csr_wr(2'b01, 12'h341, 32'h1237);
        rd("mepc_low_bits", 12'h341, 32'h1234);
        csr_wr(2'b01, 12'h123, 32'hDEAD_BEEF);
        rd("unmapped", 12'h123, 32'h0);

        // Vector address wraps at 32 bits
        redirect_expect("vec_wrap", 32'h38);
        step(1'b1, 1'b0, 4'hF, 32'h8000, 2'b00, 12'h0, 32'h0);
        redirect_check();

        // Reset in the middle of a redirect
        expect_val("rst_mid_pre_en", 32'h1);
        step(1'b0, 1'b1, 4'h0, 32'h0, 2'b00, 12'h0, 32'h0);
        cmp({31'b0, bus_if.redirect_en});
        rst_n = 1'b0;
        #1;
        expect_val("rst_mid_en", 32'h0);      cmp({31'b0, bus_if.redirect_en});
        expect_val("rst_mid_in_trap", 32'h0); cmp({31'b0, bus_if.in_trap});
        rd("rst_mid_mtvec", 12'h305, 32'h100);
        rd("rst_mid_scratch", 12'h340, 32'h0);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
